// File: rtl/uart_pkg.sv
// uart_pkg: frame geometry, sync header bytes and sender FSM states shared by packer, buffer and sender
package uart_pkg;
  localparam int NUM_BYTES = 5160;
  localparam int ADDR_W = $clog2(NUM_BYTES);
  localparam logic [7:0] HEADER0 = 8'hAA;
  localparam logic [7:0] HEADER1 = 8'h55;
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, RD_REQ, RD_WAIT, SEND, DONE} state_t;
endpackage

// File: rtl/frame_uart_sender_if.sv
// frame_uart_sender_if: frame-buffer read port (re, rAddr, rData) and uart_tx byte handshake (tx_data, tx_valid, tx_ready)
interface frame_uart_sender_if #(
  parameter int ADDR_W = uart_pkg::ADDR_W
) ();
  logic re;
  logic [ADDR_W-1:0] rAddr;
  logic [7:0] rData;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  modport master (output re, rAddr, tx_data, tx_valid, input rData, tx_ready);
  modport slave (input re, rAddr, tx_data, tx_valid, output rData, tx_ready);
endinterface

// File: rtl/frame_uart_sender.sv
// frame_uart_sender: streams optional AA/55 header then frame-buffer bytes 0..NUM_BYTES-1 to uart_tx; ports clk, reset, start, bus (read port + tx handshake), busy, done
module frame_uart_sender #(
  parameter int NUM_BYTES = uart_pkg::NUM_BYTES,
  parameter int ADDR_W = uart_pkg::ADDR_W,
  parameter bit HEADER_EN = 1'b1,
  parameter logic [7:0] HEADER0 = uart_pkg::HEADER0,
  parameter logic [7:0] HEADER1 = uart_pkg::HEADER1
) (
  input logic clk,
  input logic reset,
  input logic start,
  frame_uart_sender_if.master bus,
  output logic busy,
  output logic done
);
  import uart_pkg::*;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr, addr_n, raddr;
  logic [7:0] data;
  always_comb begin
    state_n = state;
    addr_n = addr;
    case (state)
      IDLE: if (start) begin
        addr_n = '0;
        state_n = HEADER_EN ? HDR0 : RD_REQ;
      end
      HDR0: state_n = bus.tx_ready ? HDR1 : HDR0;
      HDR1: state_n = bus.tx_ready ? RD_REQ : HDR1;
      RD_REQ: state_n = RD_WAIT;
      RD_WAIT: state_n = SEND;
      SEND: if (bus.tx_ready) begin
        state_n = (addr == ADDR_W'(NUM_BYTES - 1)) ? DONE : RD_REQ;
        addr_n = (addr == ADDR_W'(NUM_BYTES - 1)) ? addr : addr + ADDR_W'(1);
      end
      DONE: begin
        addr_n = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      raddr <= '0;
      data <= '0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      if (state_n == RD_REQ) raddr <= addr_n;
      if (state == RD_WAIT) data <= bus.rData;
    end
  end
  assign bus.re = state == RD_REQ;
  assign bus.rAddr = raddr;
  assign bus.tx_valid = state inside {HDR0, HDR1, SEND};
  assign bus.tx_data = state == HDR0 ? HEADER0 : state == HDR1 ? HEADER1 : data;
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule
